// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one multi-cycle-settling ALU between two requesters.
// Round-robin arbitration, operand latch, fixed settle window, then a
// valid/ready response tagged with the requester id.
module alu_share_ctrl #(
  parameter int WIDTH  = 32,
  parameter int SETTLE = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carryout,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic [2:0]       resp_flags,
  output logic             busy
);

  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state_r;
  logic             last_grant_r;
  logic [CW-1:0]    counter_r;
  logic [WIDTH-1:0] alu_a_r;
  logic [WIDTH-1:0] alu_b_r;
  logic [2:0]       alu_op_r;
  logic             resp_valid_r;
  logic             resp_id_r;
  logic [WIDTH-1:0] resp_result_r;
  logic [2:0]       resp_flags_r;

  logic             grant_s;
  logic             grant_vld_s;
  logic             idle_s;
  logic             ready0_s;
  logic             ready1_s;
  logic             accept_s;
  logic [WIDTH-1:0] sel_a_s;
  logic [WIDTH-1:0] sel_b_s;
  logic [2:0]       sel_op_s;

  // Round-robin pick: a lone requester always wins, a tie goes to the one not served last.
  always_comb begin
    grant_s     = 1'b0;
    grant_vld_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s     = ~last_grant_r;
      grant_vld_s = 1'b1;
    end else if (req0_valid) begin
      grant_s     = 1'b0;
      grant_vld_s = 1'b1;
    end else if (req1_valid) begin
      grant_s     = 1'b1;
      grant_vld_s = 1'b1;
    end else begin
      grant_s     = 1'b0;
      grant_vld_s = 1'b0;
    end
  end

  assign idle_s   = (state_r == IDLE) && !reset;
  assign ready0_s = idle_s && grant_vld_s && (grant_s == 1'b0);
  assign ready1_s = idle_s && grant_vld_s && (grant_s == 1'b1);
  assign accept_s = ready0_s || ready1_s;

  // Steer the granted requester's operands toward the ALU input registers.
  always_comb begin
    sel_a_s  = req0_a;
    sel_b_s  = req0_b;
    sel_op_s = req0_op;
    if (grant_s) begin
      sel_a_s  = req1_a;
      sel_b_s  = req1_b;
      sel_op_s = req1_op;
    end else begin
      sel_a_s  = req0_a;
      sel_b_s  = req0_b;
      sel_op_s = req0_op;
    end
  end

  // Sequencer: accept, hold ALU inputs for the settle window, capture, hand off.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      last_grant_r  <= 1'b1;
      counter_r     <= CNT_ZERO;
      alu_a_r       <= '0;
      alu_b_r       <= '0;
      alu_op_r      <= 3'd0;
      resp_valid_r  <= 1'b0;
      resp_id_r     <= 1'b0;
      resp_result_r <= '0;
      resp_flags_r  <= 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            alu_a_r      <= sel_a_s;
            alu_b_r      <= sel_b_s;
            alu_op_r     <= sel_op_s;
            resp_id_r    <= grant_s;
            last_grant_r <= grant_s;
            counter_r    <= CNT_LOAD;
            state_r      <= WAIT;
          end
        end
        WAIT: begin
          // ALU inputs have been stable for the full window once the count reaches one.
          if (counter_r == CNT_ONE) begin
            resp_result_r <= alu_result;
            resp_flags_r  <= {alu_carryout, alu_zero, alu_overflow};
            resp_valid_r  <= 1'b1;
            counter_r     <= CNT_ZERO;
            state_r       <= RESP;
          end else begin
            counter_r <= counter_r - CNT_ONE;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_r <= 1'b0;
            state_r      <= IDLE;
          end
        end
        default: begin
          resp_valid_r <= 1'b0;
          counter_r    <= CNT_ZERO;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign req0_ready  = ready0_s;
  assign req1_ready  = ready1_s;
  assign alu_a       = alu_a_r;
  assign alu_b       = alu_b_r;
  assign alu_op      = alu_op_r;
  assign resp_valid  = resp_valid_r;
  assign resp_id     = resp_id_r;
  assign resp_result = resp_result_r;
  assign resp_flags  = resp_flags_r;
  assign busy        = (state_r != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Testbench for alu_share_ctrl: external ALU model with settle-time behaviour,
// timestamp-based reference model checked every cycle, vector table, corner
// sequences and a randomized phase.
module tb_alu_share_ctrl;

  localparam int WIDTH  = 32;
  localparam int SETTLE = 3;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_XOR = 3'd2, OP_SLT = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4, OP_NAND = 3'd5, OP_NOR = 3'd6, OP_OR = 3'd7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic req0_ready, req1_ready;
  logic [31:0] req0_a = 32'd0, req0_b = 32'd0, req1_a = 32'd0, req1_b = 32'd0;
  logic [2:0] req0_op = 3'd0, req1_op = 3'd0;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_op;
  logic alu_carryout, alu_zero, alu_overflow;
  logic resp_valid, resp_id, busy;
  logic resp_ready = 1'b1;
  logic [31:0] resp_result;
  logic [2:0] resp_flags;

  int checks = 0;
  int errors = 0;

  alu_share_ctrl #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .alu_carryout(alu_carryout), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_flags(resp_flags), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU: returns {carryout, zero, overflow, result}
  function automatic logic [34:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    s = 33'd0; r = 32'd0; c = 1'b0; v = 1'b0;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      OP_SUB: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; c = s[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      OP_XOR:  r = a ^ b;
      OP_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_AND:  r = a & b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_OR:   r = a | b;
      default: r = 32'd0;
    endcase
    return {c, (r == 32'd0), v, r};
  endfunction

  // ALU model: output is wrong until its inputs have been stable long enough.
  logic [66:0] alu_last_in = '0;
  int alu_age = 0;
  logic [34:0] alu_good;
  assign alu_good = alu_ref(alu_a, alu_b, alu_op);
  assign alu_result = (alu_age >= SETTLE - 1) ? alu_good[31:0] : ~alu_good[31:0];
  assign {alu_carryout, alu_zero, alu_overflow} = (alu_age >= SETTLE - 1) ? alu_good[34:32] : ~alu_good[34:32];

  always @(negedge clk) begin
    if ({alu_a, alu_b, alu_op} !== alu_last_in) begin
      alu_last_in <= {alu_a, alu_b, alu_op};
      alu_age <= 0;
    end else if (alu_age < 1000) begin
      alu_age <= alu_age + 1;
    end
  end

  // Reference model: one outstanding operation with a response timestamp.
  bit m_busy = 1'b0;
  bit m_last = 1'b1;
  bit m_id = 1'b0;
  logic [31:0] m_alu_a = 32'd0, m_alu_b = 32'd0;
  logic [2:0] m_alu_op = 3'd0;
  logic [34:0] m_res = '0;
  int mcyc = 0;
  int m_resp_at = 0;
  bit chk_en = 1'b0;

  function automatic bit exp_rdy(input bit id);
    if (reset || m_busy) return 1'b0;
    if (id == 1'b0) return req0_valid && (!req1_valid || m_last == 1'b1);
    return req1_valid && (!req0_valid || m_last == 1'b0);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0; m_last <= 1'b1; m_alu_a <= 32'd0; m_alu_b <= 32'd0; m_alu_op <= 3'd0;
    end else if (!m_busy) begin
      if (exp_rdy(1'b0)) begin
        m_busy <= 1'b1; m_last <= 1'b0; m_id <= 1'b0;
        m_alu_a <= req0_a; m_alu_b <= req0_b; m_alu_op <= req0_op;
        m_res <= alu_ref(req0_a, req0_b, req0_op);
        m_resp_at <= mcyc + SETTLE + 1;
      end else if (exp_rdy(1'b1)) begin
        m_busy <= 1'b1; m_last <= 1'b1; m_id <= 1'b1;
        m_alu_a <= req1_a; m_alu_b <= req1_b; m_alu_op <= req1_op;
        m_res <= alu_ref(req1_a, req1_b, req1_op);
        m_resp_at <= mcyc + SETTLE + 1;
      end
    end else if (mcyc >= m_resp_at && resp_ready) begin
      m_busy <= 1'b0;
    end
    mcyc <= mcyc + 1;
  end

  // Per-cycle comparison against the reference model
  always @(negedge clk) begin
    if (chk_en) begin
      bit ev;
      ev = m_busy && (mcyc >= m_resp_at);
      check("req0_ready", 64'(req0_ready), 64'(exp_rdy(1'b0)));
      check("req1_ready", 64'(req1_ready), 64'(exp_rdy(1'b1)));
      check("busy", 64'(busy), 64'(m_busy));
      check("resp_valid", 64'(resp_valid), 64'(ev));
      check("alu_a", 64'(alu_a), 64'(m_alu_a));
      check("alu_b", 64'(alu_b), 64'(m_alu_b));
      check("alu_op", 64'(alu_op), 64'(m_alu_op));
      if (ev) begin
        check("resp_id", 64'(resp_id), 64'(m_id));
        check("resp_data", 64'({resp_flags, resp_result}), 64'(m_res));
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1;
    check("ready0_in_reset", 64'(req0_ready), 64'd0);
    check("ready1_in_reset", 64'(req1_ready), 64'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; reset = 1'b0; chk_en = 1'b1;
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_alu", 64'({alu_a, alu_op}), 64'd0);
    check("rst_alu_b", 64'(alu_b), 64'd0);
    check("rst_resp", 64'({resp_id, resp_flags, resp_result}), 64'd0);
  endtask

  task automatic drain();
    int n;
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1; n = 0;
    while ((busy || resp_valid) && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check("drain_idle", 64'(busy || resp_valid), 64'd0);
  endtask

  task automatic run_op(input bit id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        output logic [34:0] got, output bit gid, output int lat);
    int n;
    bit acc;
    got = '0; gid = 1'b0; lat = 0; acc = 1'b0; n = 0;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
    else begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
    while (!acc && n < 20) begin
      @(negedge clk); acc = id ? req1_ready : req0_ready; n++;
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("accept_seen", 64'(acc), 64'd1);
    n = 0;
    if (acc) begin
      acc = 1'b0;
      while (!acc && n < 20) begin
        @(negedge clk); n++;
        if (resp_valid) begin acc = 1'b1; got = {resp_flags, resp_result}; gid = resp_id; end
        @(posedge clk); #1;
      end
      lat = n;
      check("resp_seen", 64'(acc), 64'd1);
    end
  endtask

  typedef struct {
    bit          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] exp_res;
    logic [2:0]  exp_fl;
  } vec_t;

  vec_t vecs[13];

  // Two-requester burst recorder shared by the tie and lone-requester sequences
  task automatic record(input int cycles, output int gcnt, output int rcnt,
                        output bit gids[8], output int gcyc[8], output logic [34:0] rres[8], output bit rids[8]);
    gcnt = 0; rcnt = 0;
    for (int i = 0; i < 8; i++) begin gids[i] = 1'b0; gcyc[i] = 0; rres[i] = '0; rids[i] = 1'b0; end
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (gcnt < 8 && req0_valid && req0_ready) begin gids[gcnt] = 1'b0; gcyc[gcnt] = c; gcnt++; end
      if (gcnt < 8 && req1_valid && req1_ready) begin gids[gcnt] = 1'b1; gcyc[gcnt] = c; gcnt++; end
      if (rcnt < 8 && resp_valid) begin rres[rcnt] = {resp_flags, resp_result}; rids[rcnt] = resp_id; rcnt++; end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete (checks %0d)", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [34:0] got;
    bit gid, bgot;
    int lat, gcnt, rcnt, n;
    bit gids[8], rids[8];
    int gcyc[8];
    logic [34:0] rres[8];

    vecs[0]  = '{1'b0, 32'hF0F0_FFFF, 32'h0FF0_00FF, OP_AND,  32'h00F0_00FF, 3'b000};
    vecs[1]  = '{1'b1, 32'h0000_0001, 32'h0000_0002, OP_ADD,  32'h0000_0003, 3'b000};
    vecs[2]  = '{1'b0, 32'h0000_0005, 32'h0000_0005, OP_SUB,  32'h0000_0000, 3'b110};
    vecs[3]  = '{1'b1, 32'hFFFF_FFFB, 32'h0000_0003, OP_SLT,  32'h0000_0001, 3'b000};
    vecs[4]  = '{1'b0, 32'h0000_0003, 32'hFFFF_FFFB, OP_SLT,  32'h0000_0000, 3'b010};
    vecs[5]  = '{1'b1, 32'h7FFF_FFFF, 32'h0000_0001, OP_ADD,  32'h8000_0000, 3'b001};
    vecs[6]  = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, OP_ADD,  32'h0000_0000, 3'b110};
    vecs[7]  = '{1'b1, 32'hAAAA_5555, 32'hFFFF_0000, OP_XOR,  32'h5555_5555, 3'b000};
    vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, OP_NOR,  32'hFFFF_FFFF, 3'b000};
    vecs[9]  = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_NAND, 32'h0000_0000, 3'b010};
    vecs[10] = '{1'b0, 32'h1234_0000, 32'h0000_5678, OP_OR,   32'h1234_5678, 3'b000};
    vecs[11] = '{1'b1, 32'h0000_0003, 32'h0000_0005, OP_SUB,  32'hFFFF_FFFE, 3'b000};
    vecs[12] = '{1'b0, 32'h8000_0000, 32'h0000_0001, OP_SUB,  32'h7FFF_FFFF, 3'b101};

    // Vector table, one operation at a time with resp_ready high
    do_reset();
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op, got, gid, lat);
      check("vec_result", 64'(got[31:0]), 64'(vecs[i].exp_res));
      check("vec_flags", 64'(got[34:32]), 64'(vecs[i].exp_fl));
      check("vec_id", 64'(gid), 64'(vecs[i].id));
      check("vec_latency", 64'(lat), 64'(SETTLE + 1));
    end
    drain();

    // Tie after reset: req0 first, then strict alternation
    do_reset();
    req0_a = 32'd1; req0_b = 32'd2; req0_op = OP_ADD;
    req1_a = 32'd5; req1_b = 32'd5; req1_op = OP_SUB;
    req0_valid = 1'b1; req1_valid = 1'b1;
    record(20, gcnt, rcnt, gids, gcyc, rres, rids);
    check("tie_grants", 64'(gcnt), 64'd4);
    check("tie_resps", 64'(rcnt), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check("tie_grant_order", 64'(gids[i]), 64'(i % 2));
      check("tie_resp_id", 64'(rids[i]), 64'(i % 2));
      check("tie_resp", 64'(rres[i]), (i % 2 == 1) ? {29'd0, 3'b110, 32'd0} : {29'd0, 3'b000, 32'd3});
    end
    drain();

    // Backpressure: stall 10 cycles in RESP with both requesters pending
    do_reset();
    resp_ready = 1'b0;
    req0_a = 32'h1234_0000; req0_b = 32'h0000_5678; req0_op = OP_OR;
    req1_a = 32'd1; req1_b = 32'd1; req1_op = OP_ADD;
    req0_valid = 1'b1; req1_valid = 1'b1;
    bgot = 1'b0; n = 0;
    while (!bgot && n < 20) begin
      @(negedge clk); n++;
      if (resp_valid) bgot = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("bp_resp_seen", 64'(bgot), 64'd1);
    for (int c = 0; c < 10; c++) begin
      check("bp_valid", 64'(resp_valid), 64'd1);
      check("bp_result", 64'(resp_result), 64'h1234_5678);
      check("bp_ready", 64'({req0_ready, req1_ready}), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_busy", 64'({busy, resp_valid}), 64'd0);
    check("bp_next_grant", 64'({req0_ready, req1_ready}), 64'b01);
    @(posedge clk); #1;
    drain();

    // Operand change after accept has no effect
    do_reset();
    req0_a = 32'd10; req0_b = 32'd20; req0_op = OP_ADD; req0_valid = 1'b1;
    @(negedge clk);
    check("chg_accept", 64'(req0_ready), 64'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req0_a = 32'd999; req0_b = 32'd5; req0_op = OP_XOR;
    for (int c = 1; c <= SETTLE; c++) begin
      @(negedge clk);
      check("chg_alu_a", 64'(alu_a), 64'd10);
      check("chg_alu_b", 64'(alu_b), 64'd20);
      @(posedge clk); #1;
      req0_a = req0_a + 32'd1;
    end
    @(negedge clk);
    check("chg_valid", 64'(resp_valid), 64'd1);
    check("chg_result", 64'(resp_result), 64'd30);
    @(posedge clk); #1;
    drain();

    // Reset in the middle of WAIT
    do_reset();
    req0_a = 32'h11; req0_b = 32'h22; req0_op = OP_ADD; req0_valid = 1'b1;
    @(negedge clk);
    check("rw_accept", 64'(req0_ready), 64'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rw_busy_before", 64'(busy), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rw_resp_valid", 64'(resp_valid), 64'd0);
    check("rw_busy", 64'(busy), 64'd0);
    check("rw_alu_a", 64'(alu_a), 64'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("rw_tie_prio", 64'({req0_ready, req1_ready}), 64'b10);
    @(posedge clk); #1;
    drain();

    // Lone requester back to back
    do_reset();
    req1_a = 32'hFFFF_FFFB; req1_b = 32'd3; req1_op = OP_SLT; req1_valid = 1'b1;
    record(20, gcnt, rcnt, gids, gcyc, rres, rids);
    check("lone_grants", 64'(gcnt), 64'd4);
    check("lone_resps", 64'(rcnt), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check("lone_grant_cycle", 64'(gcyc[i]), 64'(5 * i));
      check("lone_grant_id", 64'(gids[i]), 64'd1);
      check("lone_resp_id", 64'(rids[i]), 64'd1);
      check("lone_result", 64'(rres[i]), 64'd1);
    end
    drain();

    // Randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      resp_ready = ($urandom_range(0, 3) != 0);
      req0_op = 3'($urandom_range(0, 7));
      req1_op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: begin req0_a = 32'($urandom_range(0, 7)); req1_b = 32'h8000_0000; end
        1: begin req0_a = 32'hFFFF_FFFF - 32'($urandom_range(0, 7)); req1_b = 32'h7FFF_FFFF; end
        default: begin req0_a = $urandom; req1_b = $urandom; end
      endcase
      req0_b = ($urandom_range(0, 1) == 0) ? req0_a : $urandom;
      req1_a = $urandom;
      @(posedge clk); #1;
    end
    reset = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
